// File: rtl/irq_ctrl_n.sv
// irq_ctrl_n: NIRQ-source interrupt controller, fixed priority (lowest index wins),
// per-channel enable and edge/level mode, one CPU request line with a timer qualifier.
// Ports: clk/rst (sync, active high); a/d/we/spo register window (spo combinational);
//        irq source lines; interrupt/int_istimer registered request; int_reply CPU ack pulse.
module irq_ctrl_n #(
    parameter int          NIRQ     = 8,
    parameter int          TIMER_CH = 0,
    parameter logic [31:0] MODE_RST = 32'h0,
    parameter int          IDW      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    input  logic [NIRQ-1:0] irq,
    output logic            interrupt,
    output logic            int_istimer,
    input  logic            int_reply
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t          state;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] enable;
    logic [NIRQ-1:0] mode;
    logic            en;
    logic [IDW-1:0]  cur_id;

    logic            wr_pend;
    logic            wr_enable;
    logic            wr_mode;
    logic            wr_ctrl;
    logic            complete;
    logic [NIRQ-1:0] mode_nxt;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] done_clr;
    logic [NIRQ-1:0] edge_nxt;
    logic [NIRQ-1:0] pending_nxt;
    logic [NIRQ-1:0] req_vec;
    logic [IDW-1:0]  sel_id;

    // Bits of d above NIRQ are intentionally dropped on every register write.
    logic unused_d;
    assign unused_d = ^d;

    assign wr_pend   = we && (a == 3'd0);
    assign wr_enable = we && (a == 3'd1);
    assign wr_mode   = we && (a == 3'd2);
    assign wr_ctrl   = we && (a == 3'd4);
    assign complete  = (state == REQ) && int_reply;

    // Pending next-state. The mode being written this cycle is used so a channel
    // switched to level tracks its line immediately, and one switched to edge keeps
    // its current pending bit. Set beats clear on edge channels.
    always_comb begin
        mode_nxt    = wr_mode ? d[NIRQ-1:0] : mode;
        rise        = irq & ~irq_q;
        w1c         = wr_pend ? d[NIRQ-1:0] : '0;
        done_clr    = complete ? (NIRQ'(1) << cur_id) : '0;
        edge_nxt    = (pending & ~(w1c | done_clr)) | rise;
        // Level channels load irq so that pending equals irq_q every cycle.
        pending_nxt = (mode_nxt & edge_nxt) | (~mode_nxt & irq);
    end

    // Lowest-index enabled pending source.
    always_comb begin
        req_vec = pending & enable;
        sel_id  = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= MODE_RST[NIRQ-1:0];
            en      <= 1'b0;
        end else begin
            irq_q   <= irq;
            pending <= pending_nxt;
            mode    <= mode_nxt;
            if (wr_enable) begin
                enable <= d[NIRQ-1:0];
            end
            if (wr_ctrl) begin
                en <= d[0];
            end
        end
    end

    // Request FSM. HOLD inserts one forced low cycle after completion so a level
    // source has time to drop before it can be re-arbitrated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            interrupt   <= 1'b0;
            int_istimer <= 1'b0;
            cur_id      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (|req_vec)) begin
                        cur_id      <= sel_id;
                        state       <= REQ;
                        interrupt   <= 1'b1;
                        int_istimer <= (sel_id == IDW'(TIMER_CH));
                    end
                end
                REQ: begin
                    if (int_reply) begin
                        state       <= HOLD;
                        interrupt   <= 1'b0;
                        int_istimer <= 1'b0;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    interrupt   <= 1'b0;
                    int_istimer <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        spo = '0;
        case (a)
            3'd0: spo = 32'(pending);
            3'd1: spo = 32'(enable);
            3'd2: spo = 32'(mode);
            3'd3: spo = (state == REQ) ? (32'h8000_0000 | 32'(cur_id)) : 32'hFFFF_FFFF;
            3'd4: spo = {30'b0, (state != IDLE), en};
            default: spo = '0;
        endcase
    end

endmodule
